transition_pair_sequencer: RTL
==============================

// Module: transition_pair_sequencer
// PURPOSE
//  Hardware stimulus sequencer for power/correlation characterisation of masked gadgets.
//  Drives an N_IN-bit input vector into the DUT as ordered transition pairs (i -> j).
//  Each vector is held HOLD_CYCLES clocks; pulses mark the trace window of every pair.
//  Three enumeration modes; a stall input back-pressures the trace-capture side.
// PARAMETERS
//  N_IN         4  DUT input bits (shares + randoms), legal 1..8
//  HOLD_CYCLES  5  clocks each vector is held, legal >=1
// PORTS
//  clk          in   1          clock, rising edge
//  rst_n        in   1          async active-low reset
//  start        in   1          begin run; sampled only in IDLE
//  abort        in   1          sync abort; return to IDLE, no done pulse
//  mode         in   2          00 exhaustive, 01 single-bit flip, 10 fixed-i sweep, 11 reserved (= 00)
//  fixed_vec    in   N_IN       initial vector i for mode 10
//  stall        in   1          capture side not ready; blocks completion of HOLD_J
//  vec_out      out  N_IN       vector applied to DUT (registered)
//  phase        out  1          0 = holding i, 1 = holding j
//  sim_idx      out  2*N_IN     index of current pair, from 0
//  trace_start  out  1          1-cycle pulse: first cycle j is on vec_out
//  trace_end    out  1          1-cycle pulse: last cycle of the pair window
//  busy         out  1          high outside IDLE
//  done         out  1          1-cycle pulse after last pair
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0.
//  FSM: IDLE -> HOLD_I -> HOLD_J -> (HOLD_I | DONE) -> IDLE.
//  IDLE: start=1 latches mode and fixed_vec; next edge vec_out=first i, phase=0, sim_idx=0, HOLD_I.
//  HOLD_I: hold_cnt counts 0..HOLD_CYCLES-1; at terminal count vec_out<=j, phase<=1,
//   trace_start<=1 (high exactly first HOLD_J cycle), hold_cnt<=0.
//  HOLD_J: terminal count AND stall=0 -> trace_end high that cycle (comb. decode);
//   at the edge: last pair -> DONE, else vec_out<=next i, phase<=0, sim_idx++, HOLD_I.
//   stall=1 at terminal count: hold_cnt saturates, vec_out held at j, no trace_end.
//   stall is ignored before terminal count.
//  DONE: done=1 one cycle, vec_out<=0, then IDLE. busy=0 in IDLE only.
//  Pair order (i outer, inner index fastest):
//   00: i=0..2^N-1, j=0..2^N-1, i==j included; 2^(2N) pairs.
//   01: i=0..2^N-1, k=0..N-1, j=i^(1<<k); N*2^N pairs.
//   10: i=fixed_vec, j=0..2^N-1; 2^N pairs.
//  Pair length with no stall: exactly 2*HOLD_CYCLES clocks.
//  sim_idx max = pairs-1; never wraps within a run; 2*N_IN bits covers mode 00.
//  start while busy: ignored. start and abort together in IDLE: abort wins, stays IDLE.
//  abort in any non-IDLE state: next edge IDLE, vec_out=0, phase=0, no done/trace_end pulse.
//  rst_n low mid-run: immediate clear to reset values; no pulse emitted.
//  mode/fixed_vec changes during run: no effect (latched copies).
// TESTING
//  T1 N_IN=2,HOLD=2,mode 00,start: vec_out 0,0,0,0,0,0,1,1,... 16 pairs, 16 trace_start/end, done 64 clk after HOLD_I entry.
//  T2 mode 01,N_IN=2: pairs (0->1),(0->2),(1->0),(1->3),(2->3),(2->0),(3->2),(3->1); done after 8.
//  T3 mode 10,fixed_vec=2'b10: pairs (2->0),(2->1),(2->2),(2->3); sim_idx 0..3; done after 4.
//  T4 stall=1 at HOLD_J terminal of pair 0 for 3 clk: vec_out stays j, sim_idx=0, trace_end once after release.
//  T5 abort during pair 5 HOLD_J: next edge busy=0, vec_out=0, no done; new start restarts at sim_idx 0.
//  T6 rst_n low mid HOLD_I (async, between edges): outputs 0 immediately; start during busy ignored.

Source files
------------

// File: rtl/transition_pair_sequencer.sv
// Transition-pair stimulus sequencer: walks ordered (i -> j) input-vector pairs,
// holds each vector HOLD_CYCLES clocks and marks the j-window with trace pulses.
module transition_pair_sequencer #(
    parameter int N_IN        = 4,
    parameter int HOLD_CYCLES = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [N_IN-1:0]   fixed_vec,
    input  logic              stall,
    output logic [N_IN-1:0]   vec_out,
    output logic              phase,
    output logic [2*N_IN-1:0] sim_idx,
    output logic              trace_start,
    output logic              trace_end,
    output logic              busy,
    output logic              done
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int IW = 2 * N_IN;
    localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] K_LAST    = N_IN'(N_IN - 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD_I, S_HOLD_J, S_DONE} state_t;
    typedef enum logic [1:0] {M_EXH = 2'b00, M_FLIP = 2'b01, M_FIXED = 2'b10} mode_t;

    state_t            state_q;
    mode_t             mode_q;
    logic [CW-1:0]     hold_cnt_q;
    logic [N_IN-1:0]   i_q;
    logic [N_IN-1:0]   inner_q;
    logic [N_IN-1:0]   vec_out_q;
    logic              phase_q;
    logic [IW-1:0]     sim_idx_q;
    logic              trace_start_q;
    logic              busy_q;
    logic              done_q;

    logic [N_IN-1:0]   j_vec;
    logic [N_IN-1:0]   next_i;
    logic [N_IN-1:0]   next_inner;
    logic              last_inner;
    logic              last_pair;
    logic              hold_last;

    assign hold_last = (hold_cnt_q == HOLD_LAST);

    // inner_q is j in modes 00/10 and the flipped bit position k in mode 01
    always_comb begin
        j_vec      = inner_q;
        last_inner = (inner_q == '1);
        if (mode_q == M_FLIP) begin
            j_vec      = i_q ^ (N_IN'(1) << inner_q);
            last_inner = (inner_q == K_LAST);
        end
        last_pair  = last_inner && ((mode_q == M_FIXED) || (i_q == '1));
        next_i     = (last_inner && (mode_q != M_FIXED)) ? i_q + N_IN'(1) : i_q;
        next_inner = last_inner ? '0 : inner_q + N_IN'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mode_q        <= M_EXH;
            hold_cnt_q    <= '0;
            i_q           <= '0;
            inner_q       <= '0;
            vec_out_q     <= '0;
            phase_q       <= 1'b0;
            sim_idx_q     <= '0;
            trace_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            trace_start_q <= 1'b0;
            done_q        <= 1'b0;
            if (abort && (state_q != S_IDLE)) begin
                state_q    <= S_IDLE;
                hold_cnt_q <= '0;
                vec_out_q  <= '0;
                phase_q    <= 1'b0;
                sim_idx_q  <= '0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            mode_q     <= (mode == 2'b11) ? M_EXH : mode_t'(mode);
                            i_q        <= (mode == 2'b10) ? fixed_vec : '0;
                            vec_out_q  <= (mode == 2'b10) ? fixed_vec : '0;
                            inner_q    <= '0;
                            phase_q    <= 1'b0;
                            sim_idx_q  <= '0;
                            hold_cnt_q <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= S_HOLD_I;
                        end
                    end
                    S_HOLD_I: begin
                        if (hold_last) begin
                            vec_out_q     <= j_vec;
                            phase_q       <= 1'b1;
                            trace_start_q <= 1'b1;
                            hold_cnt_q    <= '0;
                            state_q       <= S_HOLD_J;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + CW'(1);
                        end
                    end
                    S_HOLD_J: begin
                        // a stalled terminal count simply holds everything in place
                        if (!hold_last) begin
                            hold_cnt_q <= hold_cnt_q + CW'(1);
                        end else if (!stall) begin
                            hold_cnt_q <= '0;
                            phase_q    <= 1'b0;
                            if (last_pair) begin
                                vec_out_q <= '0;
                                done_q    <= 1'b1;
                                state_q   <= S_DONE;
                            end else begin
                                i_q       <= next_i;
                                inner_q   <= next_inner;
                                vec_out_q <= next_i;
                                sim_idx_q <= sim_idx_q + IW'(1);
                                state_q   <= S_HOLD_I;
                            end
                        end
                    end
                    S_DONE: begin
                        sim_idx_q <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign trace_end   = (state_q == S_HOLD_J) && hold_last && !stall && !abort;
    assign vec_out     = vec_out_q;
    assign phase       = phase_q;
    assign sim_idx     = sim_idx_q;
    assign trace_start = trace_start_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
